// File: rtl/ins_loader.sv
// Front-panel instruction loader: assembles a 32-bit word from hex nibbles,
// writes it to instruction memory, reads it back and flags mismatches.
// Ports:
//   CLK, RST      clock; synchronous active-low reset
//   load_en       loader mode enable
//   nibble        hex digit from the switches
//   btn_shift     debounced button; rising edge shifts nibble in
//   btn_commit    debounced button; rising edge starts write/verify
//   btn_clear     debounced button; rising edge clears buffer and err
//   R_Ins         memory read data (one cycle after address)
//   WE/W_Ins      memory write strobe and data
//   W_Addr        memory word address
//   buf_word      assembly buffer (display)
//   nib_cnt       nibbles entered, 0..8
//   busy/err/wrap FSM active, sticky mismatch, sticky address wrap
module ins_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load_en,
  input  logic [3:0]        nibble,
  input  logic              btn_shift,
  input  logic              btn_commit,
  input  logic              btn_clear,
  input  logic [31:0]       R_Ins,
  output logic              WE,
  output logic [31:0]       W_Ins,
  output logic [ADDR_W-1:0] W_Addr,
  output logic [31:0]       buf_word,
  output logic [3:0]        nib_cnt,
  output logic              busy,
  output logic              err,
  output logic              wrap
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CHECK
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_prev_shf;
  logic              r_prev_cmt;
  logic              r_prev_clr;
  logic              r_we;
  logic [31:0]       r_wins;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_buf;
  logic [3:0]        r_cnt;
  logic              r_err;
  logic              r_wrap;

  logic w_shf_e;
  logic w_cmt_e;
  logic w_clr_e;
  logic w_act;
  logic w_clr;
  logic w_cmt;
  logic w_shf;
  logic w_chk;
  logic w_match;

  assign w_shf_e = btn_shift & ~r_prev_shf;
  assign w_cmt_e = btn_commit & ~r_prev_cmt;
  assign w_clr_e = btn_clear & ~r_prev_clr;

  // Edges are only honoured in IDLE with the loader enabled;
  // clear beats commit beats shift.
  assign w_act = load_en && (r_state == S_IDLE);
  assign w_clr = w_act & w_clr_e;
  assign w_cmt = w_act & ~w_clr_e & w_cmt_e & (r_cnt == 4'd8);
  assign w_shf = w_act & ~w_clr_e & ~w_cmt_e & w_shf_e;

  assign w_chk   = load_en && (r_state == S_CHECK);
  assign w_match = (R_Ins == r_wins);

  always_ff @(posedge CLK) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_cmt) w_next = S_WRITE;
      S_WRITE: w_next = load_en ? S_READ : S_IDLE;
      S_READ:  w_next = load_en ? S_CHECK : S_IDLE;
      S_CHECK: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_prev_shf <= 1'b1;
      r_prev_cmt <= 1'b1;
      r_prev_clr <= 1'b1;
      r_we       <= 1'b0;
      r_wins     <= '0;
      r_addr     <= '0;
      r_buf      <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_prev_shf <= btn_shift;
      r_prev_cmt <= btn_commit;
      r_prev_clr <= btn_clear;
      r_we       <= (w_next == S_WRITE);
      if (w_cmt) r_wins <= r_buf;
      unique case (1'b1)
        w_clr: begin
          r_buf <= '0;
          r_cnt <= '0;
          r_err <= 1'b0;
        end
        w_shf: begin
          r_buf <= {r_buf[27:0], nibble};
          if (r_cnt != 4'd8) r_cnt <= r_cnt + 4'd1;
        end
        w_chk: begin
          if (w_match) begin
            r_addr <= r_addr + 1'b1;
            if (&r_addr) r_wrap <= 1'b1;
            r_buf  <= '0;
            r_cnt  <= '0;
          end else begin
            r_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign WE       = r_we;
  assign W_Ins    = r_wins;
  assign W_Addr   = r_addr;
  assign buf_word = r_buf;
  assign nib_cnt  = r_cnt;
  assign busy     = (r_state != S_IDLE);
  assign err      = r_err;
  assign wrap     = r_wrap;

endmodule
